// File: rtl/sprite_cfg_pkg.sv
// Shared constants, state encoding and register payload for the sprite SPI configuration block.
package sprite_cfg_pkg;

    localparam int unsigned SPRITE_BYTES_DEF = 18;

    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;

    localparam logic [7:0] REG_BG     = 8'h00;
    localparam logic [7:0] REG_COL    = 8'h01;
    localparam logic [7:0] REG_XL     = 8'h02;
    localparam logic [7:0] REG_XH     = 8'h03;
    localparam logic [7:0] REG_YL     = 8'h04;
    localparam logic [7:0] REG_YH     = 8'h05;
    localparam logic [7:0] REG_CTRL   = 8'h06;
    localparam logic [7:0] REG_STATUS = 8'h07;
    localparam logic [7:0] BMP_BASE   = 8'h08;

    localparam int unsigned ST_W = 3;
    typedef logic [ST_W-1:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_OPCODE  = 3'd1;
    localparam state_t ST_ADDR    = 3'd2;
    localparam state_t ST_DATA_WR = 3'd3;
    localparam state_t ST_DATA_RD = 3'd4;
    localparam state_t ST_IGNORE  = 3'd5;

    typedef struct packed {
        logic [5:0] bg;
        logic [5:0] spr_col;
        logic [9:0] x;
        logic [9:0] y;
        logic       en;
    } sprite_regs_t;

    // Readback view of the shadow/status map; unmapped and bitmap addresses read as zero.
    function automatic logic [7:0] reg_read(input logic [7:0] a, input sprite_regs_t r,
                                            input logic pending, input logic [6:0] frame_cnt);
        logic [7:0] d;
        d = 8'h00;
        case (a)
            REG_BG:     d = {2'b00, r.bg};
            REG_COL:    d = {2'b00, r.spr_col};
            REG_XL:     d = r.x[7:0];
            REG_XH:     d = {6'b000000, r.x[9:8]};
            REG_YL:     d = r.y[7:0];
            REG_YH:     d = {6'b000000, r.y[9:8]};
            REG_CTRL:   d = {7'b0000000, r.en};
            REG_STATUS: d = {pending, frame_cnt};
            default:    d = 8'h00;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/sprite_cfg_ctrl_if.sv
// SPI pin bundle between the board-level master and the configuration slave.
interface sprite_cfg_ctrl_if;
    logic sclk;
    logic mosi;
    logic cs;
    logic miso;

    modport master (output sclk, output mosi, output cs, input miso);
    modport slave  (input sclk, input mosi, input cs, output miso);
endinterface

// File: rtl/spi_slave_shifter.sv
// SPI mode-0 slave bit engine: synchronisers, edge detect, rx byte assembly and tx shift register.
module spi_slave_shifter (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       cs,
    input  logic       tx_load,
    input  logic [7:0] tx_data,
    output logic       miso,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       cs_high,
    output logic       cs_fall_c
);

    logic [1:0] sclk_ff;
    logic [1:0] mosi_ff;
    logic [1:0] cs_ff;
    logic       sclk_d;
    logic       cs_d;
    logic       sclk_rise_c;
    logic       sclk_fall_c;
    logic [2:0] bit_cnt;
    logic [6:0] rx_shift;
    logic [7:0] tx_shift;

    // cs synchroniser resets to "selected" so a frame already in progress at reset release is not re-entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_ff <= 2'b00;
            mosi_ff <= 2'b00;
            cs_ff   <= 2'b00;
            sclk_d  <= 1'b0;
            cs_d    <= 1'b0;
        end else begin
            sclk_ff <= {sclk_ff[0], sclk};
            mosi_ff <= {mosi_ff[0], mosi};
            cs_ff   <= {cs_ff[0], cs};
            sclk_d  <= sclk_ff[1];
            cs_d    <= cs_ff[1];
        end
    end

    assign sclk_rise_c = sclk_ff[1] & ~sclk_d;
    assign sclk_fall_c = ~sclk_ff[1] & sclk_d;
    assign cs_fall_c   = ~cs_ff[1] & cs_d;
    assign cs_high     = cs_ff[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt    <= 3'd0;
            rx_shift   <= 7'd0;
            rx_byte    <= 8'd0;
            byte_valid <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (cs_ff[1]) begin
                bit_cnt <= 3'd0;
            end else if (sclk_rise_c) begin
                rx_shift <= {rx_shift[5:0], mosi_ff[1]};
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    rx_byte    <= {rx_shift, mosi_ff[1]};
                    byte_valid <= 1'b1;
                end
            end
        end
    end

    // A load coinciding with a falling edge presents the new MSB immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_shift <= 8'd0;
            miso     <= 1'b0;
        end else if (cs_ff[1]) begin
            tx_shift <= 8'd0;
            miso     <= 1'b0;
        end else if (tx_load) begin
            if (sclk_fall_c) begin
                miso     <= tx_data[7];
                tx_shift <= {tx_data[6:0], 1'b0};
            end else begin
                tx_shift <= tx_data;
            end
        end else if (sclk_fall_c) begin
            miso     <= tx_shift[7];
            tx_shift <= {tx_shift[6:0], 1'b0};
        end
    end

endmodule

// File: rtl/sprite_cfg_ctrl.sv
// SPI configuration controller: command FSM, shadow/active register file, frame-synchronous commit.
// Optional readback path enabled by defining SPRITE_CFG_READBACK_EN.
module sprite_cfg_ctrl
    import sprite_cfg_pkg::*;
#(
    parameter  int unsigned SPRITE_BYTES = SPRITE_BYTES_DEF,
    localparam int unsigned BMP_AW       = $clog2(SPRITE_BYTES)
) (
    input  logic              clk,
    input  logic              reset,
    sprite_cfg_ctrl_if.slave  spi,
    input  logic              next_frame,
    output logic [5:0]        bg_color,
    output logic [5:0]        sprite_color,
    output logic [9:0]        sprite_x,
    output logic [9:0]        sprite_y,
    output logic              sprite_en,
    output logic              bmp_we,
    output logic [BMP_AW-1:0] bmp_addr,
    output logic [7:0]        bmp_wdata
);

    localparam logic [7:0] BMP_END = 8'(32'(BMP_BASE) + SPRITE_BYTES);

    logic         byte_valid;
    logic [7:0]   rx_byte;
    logic         cs_high;
    logic         cs_fall_c;
    logic         tx_load_c;
    logic [7:0]   tx_data_c;
    logic [7:0]   rd_addr_c;

    state_t       state, state_nxt;
    logic [7:0]   addr, addr_nxt;
    logic         is_read, is_read_nxt;
    logic         wr_c;
    logic         reg_wr_c;
    logic         bmp_hit_c;

    sprite_regs_t shadow;
    sprite_regs_t active;
    logic         pending;
    logic [6:0]   frame_cnt;

    spi_slave_shifter u_shifter (
        .clk        (clk),
        .reset      (reset),
        .sclk       (spi.sclk),
        .mosi       (spi.mosi),
        .cs         (spi.cs),
        .tx_load    (tx_load_c),
        .tx_data    (tx_data_c),
        .miso       (spi.miso),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .cs_high    (cs_high),
        .cs_fall_c  (cs_fall_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            addr    <= 8'h00;
            is_read <= 1'b0;
        end else begin
            state   <= state_nxt;
            addr    <= addr_nxt;
            is_read <= is_read_nxt;
        end
    end

    // Command decode; every byte is consumed in the cycle its byte_valid is high.
    always_comb begin
        state_nxt   = state;
        addr_nxt    = addr;
        is_read_nxt = is_read;
        wr_c        = 1'b0;
        tx_load_c   = 1'b0;
        rd_addr_c   = addr;
        if (cs_high) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (cs_fall_c) state_nxt = ST_OPCODE;
                ST_OPCODE: if (byte_valid) begin
                    if (rx_byte == OP_WRITE) begin
                        state_nxt   = ST_ADDR;
                        is_read_nxt = 1'b0;
                    end
`ifdef SPRITE_CFG_READBACK_EN
                    else if (rx_byte == OP_READ) begin
                        state_nxt   = ST_ADDR;
                        is_read_nxt = 1'b1;
                    end
`endif
                    else begin
                        state_nxt = ST_IGNORE;
                    end
                end
                ST_ADDR: if (byte_valid) begin
                    addr_nxt  = rx_byte;
                    rd_addr_c = rx_byte;
                    tx_load_c = is_read;
                    state_nxt = is_read ? ST_DATA_RD : ST_DATA_WR;
                end
                ST_DATA_WR: if (byte_valid) begin
                    wr_c     = 1'b1;
                    addr_nxt = addr + 8'd1;
                end
                ST_DATA_RD: if (byte_valid) begin
                    addr_nxt  = addr + 8'd1;
                    rd_addr_c = addr + 8'd1;
                    tx_load_c = 1'b1;
                end
                ST_IGNORE: state_nxt = ST_IGNORE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    assign tx_data_c = reg_read(rd_addr_c, shadow, pending, frame_cnt);
    assign reg_wr_c  = wr_c && (addr < REG_STATUS);
    assign bmp_hit_c = (addr >= BMP_BASE) && (addr < BMP_END);

    // Commit copies the pre-write shadow; a same-cycle write keeps pending set for the next frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow    <= '0;
            active    <= '0;
            pending   <= 1'b0;
            frame_cnt <= 7'd0;
            bmp_we    <= 1'b0;
            bmp_addr  <= '0;
            bmp_wdata <= 8'h00;
        end else begin
            if (reg_wr_c) begin
                case (addr)
                    REG_BG:   shadow.bg      <= rx_byte[5:0];
                    REG_COL:  shadow.spr_col <= rx_byte[5:0];
                    REG_XL:   shadow.x[7:0]  <= rx_byte;
                    REG_XH:   shadow.x[9:8]  <= rx_byte[1:0];
                    REG_YL:   shadow.y[7:0]  <= rx_byte;
                    REG_YH:   shadow.y[9:8]  <= rx_byte[1:0];
                    REG_CTRL: shadow.en      <= rx_byte[0];
                    default:  shadow         <= shadow;
                endcase
            end
            if (next_frame && pending) active <= shadow;
            if (next_frame) frame_cnt <= frame_cnt + 7'd1;
            if (reg_wr_c) begin
                pending <= 1'b1;
            end else if (next_frame) begin
                pending <= 1'b0;
            end
            bmp_we <= wr_c && bmp_hit_c;
            if (wr_c && bmp_hit_c) begin
                bmp_addr  <= BMP_AW'(addr - BMP_BASE);
                bmp_wdata <= rx_byte;
            end
        end
    end

    assign bg_color     = active.bg;
    assign sprite_color = active.spr_col;
    assign sprite_x     = active.x;
    assign sprite_y     = active.y;
    assign sprite_en    = active.en;

endmodule

// File: tb/tb_sprite_cfg_ctrl.sv
// Self-checking bench for sprite_cfg_ctrl; bitmap writes and SPI readback go through scoreboard queues.
module tb_sprite_cfg_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       next_frame;
    logic [5:0] bg_color;
    logic [5:0] sprite_color;
    logic [9:0] sprite_x;
    logic [9:0] sprite_y;
    logic       sprite_en;
    logic       bmp_we;
    logic [4:0] bmp_addr;
    logic [7:0] bmp_wdata;

    int total = 0;
    int bad   = 0;

    logic [12:0] bmp_q[$];
    logic [7:0]  rd_q[$];
    bit          watch_pos = 1'b0;
    logic [9:0]  prev_x = 10'h000;
    logic [9:0]  prev_y = 10'h000;

    sprite_cfg_ctrl_if spi_if ();

    sprite_cfg_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .spi          (spi_if),
        .next_frame   (next_frame),
        .bg_color     (bg_color),
        .sprite_color (sprite_color),
        .sprite_x     (sprite_x),
        .sprite_y     (sprite_y),
        .sprite_en    (sprite_en),
        .bmp_we       (bmp_we),
        .bmp_addr     (bmp_addr),
        .bmp_wdata    (bmp_wdata)
    );

    always #5 clk = ~clk;

    // Every bitmap strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (bmp_we === 1'b1) begin
            total++;
            if (bmp_q.size() == 0) begin
                bad++;
                $display("FAIL bmp_unexpected: got addr=%0d data=%h want no write", bmp_addr, bmp_wdata);
            end else begin
                logic [12:0] e;
                e = bmp_q.pop_front();
                if ({bmp_addr, bmp_wdata} !== e) begin
                    bad++;
                    $display("FAIL bmp_write: got addr=%0d data=%h want addr=%0d data=%h",
                             bmp_addr, bmp_wdata, e[12:8], e[7:0]);
                end
            end
        end
    end

    // Position may only ever jump straight to the fully written value.
    always @(negedge clk) begin
        if (watch_pos && (sprite_x !== prev_x || sprite_y !== prev_y)) begin
            total++;
            if (sprite_x !== 10'h155 || sprite_y !== 10'h2AB) begin
                bad++;
                $display("FAIL pos_tear: got x=%h y=%h want x=155 y=2ab", sprite_x, sprite_y);
            end
            prev_x = sprite_x;
            prev_y = sprite_y;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_nf();
        next_frame = 1'b1;
        tick(1);
        next_frame = 1'b0;
        tick(2);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
    endtask

    task automatic cs_begin();
        spi_if.cs = 1'b0;
        tick(6);
    endtask

    task automatic cs_end();
        spi_if.sclk = 1'b0;
        tick(2);
        spi_if.cs = 1'b1;
        tick(6);
    endtask

    // Shifts nbits MSB-first; nf_sync aligns a next_frame pulse with the byte's decode cycle.
    task automatic spi_bits(input logic [7:0] tx, input int nbits, input bit nf_sync, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            spi_if.sclk = 1'b0;
            spi_if.mosi = tx[i];
            tick(4);
            rx = {rx[6:0], spi_if.miso};
            spi_if.sclk = 1'b1;
            if (nf_sync && i == 0) begin
                tick(3);
                next_frame = 1'b1;
                tick(1);
                next_frame = 1'b0;
                tick(4);
            end else begin
                tick(4);
            end
        end
        spi_if.sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx);
        logic [7:0] rx;
        spi_bits(tx, 8, 1'b0, rx);
    endtask

    task automatic spi_read_check(input logic [7:0] a, input logic [7:0] exp, input string name);
        logic [7:0] rx;
        logic [7:0] e;
        cs_begin();
        spi_byte(8'h03);
        spi_byte(a);
        rd_q.push_back(exp);
        spi_bits(8'h00, 8, 1'b0, rx);
        cs_end();
        e = rd_q.pop_front();
        total++;
        if (rx !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, rx, e);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(2);
        total++;
        if ({bg_color, sprite_color, sprite_x, sprite_y, sprite_en} !== 33'd0) begin
            bad++;
            $display("FAIL reset_regs: got %h want 0", {bg_color, sprite_color, sprite_x, sprite_y, sprite_en});
        end
        total++;
        if ({bmp_we, bmp_addr, bmp_wdata, spi_if.miso} !== 15'd0) begin
            bad++;
            $display("FAIL reset_bmp_miso: got %h want 0", {bmp_we, bmp_addr, bmp_wdata, spi_if.miso});
        end
        reset = 1'b0;
        tick(4);
    endtask

    task automatic test_colors();
        cs_begin();
        spi_byte(8'h02); spi_byte(8'h00); spi_byte(8'h2A); spi_byte(8'h15);
        cs_end();
        total++;
        if (bg_color !== 6'h00 || sprite_color !== 6'h00) begin
            bad++;
            $display("FAIL colors_pre_frame: got bg=%h col=%h want 00 00", bg_color, sprite_color);
        end
        pulse_nf();
        total++;
        if (bg_color !== 6'h2A || sprite_color !== 6'h15) begin
            bad++;
            $display("FAIL colors_commit: got bg=%h col=%h want 2a 15", bg_color, sprite_color);
        end
    endtask

    task automatic test_position();
        watch_pos = 1'b1;
        cs_begin();
        spi_byte(8'h02); spi_byte(8'h02); spi_byte(8'h55); spi_byte(8'h01);
        cs_end();
        cs_begin();
        spi_byte(8'h02); spi_byte(8'h04); spi_byte(8'hAB); spi_byte(8'h02);
        cs_end();
        total++;
        if (sprite_x !== 10'h000 || sprite_y !== 10'h000) begin
            bad++;
            $display("FAIL pos_pre_frame: got x=%h y=%h want 000 000", sprite_x, sprite_y);
        end
        pulse_nf();
        total++;
        if (sprite_x !== 10'h155 || sprite_y !== 10'h2AB) begin
            bad++;
            $display("FAIL pos_commit: got x=%h y=%h want 155 2ab", sprite_x, sprite_y);
        end
        watch_pos = 1'b0;
    endtask

    task automatic test_bitmap();
        cs_begin();
        spi_byte(8'h02); spi_byte(8'h08);
        for (int i = 0; i < 19; i++) begin
            logic [7:0] d;
            d = 8'(i);
            if (i < 18) bmp_q.push_back({5'(i), d});
            spi_byte(d);
        end
        cs_end();
        cs_begin();
        spi_byte(8'h02); spi_byte(8'h1A); spi_byte(8'h55);
        cs_end();
        cs_begin();
        spi_byte(8'h02); spi_byte(8'h07); spi_byte(8'hFF);
        cs_end();
        total++;
        if (bmp_q.size() != 0) begin
            bad++;
            $display("FAIL bmp_count: got %0d writes missing want 0", bmp_q.size());
        end
    endtask

    task automatic test_wrap_and_masking();
        cs_begin();
        spi_byte(8'h02); spi_byte(8'hFF); spi_byte(8'h11); spi_byte(8'h22);
        cs_end();
        cs_begin();
        spi_byte(8'h02); spi_byte(8'h01); spi_byte(8'hFF);
        cs_end();
        pulse_nf();
        total++;
        if (bg_color !== 6'h22 || sprite_color !== 6'h3F) begin
            bad++;
            $display("FAIL wrap_mask: got bg=%h col=%h want 22 3f", bg_color, sprite_color);
        end
    endtask

    task automatic test_abort();
        logic [7:0] rx;
        cs_begin();
        spi_byte(8'h02); spi_byte(8'h00);
        spi_bits(8'h3F, 5, 1'b0, rx);
        cs_end();
        cs_begin();
        spi_byte(8'h02); spi_byte(8'h08);
        spi_bits(8'hA5, 5, 1'b0, rx);
        cs_end();
        pulse_nf();
        total++;
        if (bg_color !== 6'h22 || bmp_q.size() != 0) begin
            bad++;
            $display("FAIL abort_partial: got bg=%h pending_bmp=%0d want 22 0", bg_color, bmp_q.size());
        end
        cs_begin();
        spi_byte(8'h02); spi_byte(8'h06); spi_byte(8'h01);
        cs_end();
        total++;
        if (sprite_en !== 1'b0) begin
            bad++;
            $display("FAIL en_pre_frame: got %b want 0", sprite_en);
        end
        pulse_nf();
        total++;
        if (sprite_en !== 1'b1) begin
            bad++;
            $display("FAIL en_commit: got %b want 1", sprite_en);
        end
    endtask

    task automatic test_readback();
        do_reset();
        repeat (3) pulse_nf();
`ifdef SPRITE_CFG_READBACK_EN
        spi_read_check(8'h07, 8'h03, "rd_status_idle");
`else
        spi_read_check(8'h07, 8'h00, "rd_status_idle");
`endif
        cs_begin();
        spi_byte(8'h02); spi_byte(8'h01); spi_byte(8'h15);
        cs_end();
`ifdef SPRITE_CFG_READBACK_EN
        spi_read_check(8'h01, 8'h15, "rd_spr_col");
        spi_read_check(8'h07, 8'h83, "rd_status_pending");
        spi_read_check(8'h0A, 8'h00, "rd_bitmap_zero");
`else
        spi_read_check(8'h01, 8'h00, "rd_spr_col");
        spi_read_check(8'h07, 8'h00, "rd_status_pending");
`endif
        pulse_nf();
        total++;
        if (bg_color !== 6'h00 || sprite_color !== 6'h15) begin
            bad++;
            $display("FAIL rd_no_side_effect: got bg=%h col=%h want 00 15", bg_color, sprite_color);
        end
    endtask

    task automatic test_coincident();
        logic [7:0] rx;
        cs_begin();
        spi_byte(8'h02); spi_byte(8'h00); spi_byte(8'h11);
        cs_end();
        cs_begin();
        spi_byte(8'h02); spi_byte(8'h00);
        spi_bits(8'h2A, 8, 1'b1, rx);
        cs_end();
        total++;
        if (bg_color !== 6'h11) begin
            bad++;
            $display("FAIL coincident_old: got %h want 11", bg_color);
        end
        pulse_nf();
        total++;
        if (bg_color !== 6'h2A) begin
            bad++;
            $display("FAIL coincident_next: got %h want 2a", bg_color);
        end
    endtask

    task automatic test_reset_mid_transfer();
        cs_begin();
        spi_byte(8'h02); spi_byte(8'h08);
        do_reset();
        total++;
        if (bg_color !== 6'h00 || sprite_color !== 6'h00) begin
            bad++;
            $display("FAIL midreset_clear: got bg=%h col=%h want 00 00", bg_color, sprite_color);
        end
        spi_byte(8'hAA); spi_byte(8'hAB);
        cs_end();
        cs_begin();
        bmp_q.push_back({5'd0, 8'h5A});
        spi_byte(8'h02); spi_byte(8'h08); spi_byte(8'h5A);
        cs_end();
        total++;
        if (bmp_q.size() != 0) begin
            bad++;
            $display("FAIL midreset_recover: got %0d writes missing want 0", bmp_q.size());
        end
    endtask

    initial begin
        reset       = 1'b0;
        next_frame  = 1'b0;
        spi_if.cs   = 1'b1;
        spi_if.sclk = 1'b0;
        spi_if.mosi = 1'b0;
        test_reset();
        test_colors();
        test_position();
        test_bitmap();
        test_wrap_and_masking();
        test_abort();
        test_readback();
        test_coincident();
        test_reset_mid_transfer();
        tick(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
